// File: rtl/mask_range_sched.sv
// mask_range_sched: arbitrates range requests from two requesters (round-robin) in front of
// the shared 32-bit mask generator. Each grant runs the generator twice (left bound, then
// right bound) and returns the AND of the two masks with a one-cycle ack. A watchdog aborts
// a run whose done never rises. Every output is driven straight from a flop.
//
// Ports:
//   i_clk, i_rstn           clock, asynchronous active-low reset
//   i_req0/1                request level, held until the matching ack
//   i_left0/1, i_right0/1   bound indices, stable while the request is high
//   o_ack0/1                one-cycle completion pulse
//   o_err                   pulses with the ack when the run timed out
//   o_mask                  AND of left/right masks in the ack cycle, 0 otherwise
//   o_busy                  high whenever the FSM is not idle
//   o_mg_trig               generator trig (level)
//   o_mg_left_or_right      generator select: 0 = left, 1 = right
//   o_mg_bound_index        generator bound index (held stable for the whole run)
//   i_mg_done, i_mg_mask    generator done level and mask (mask valid while done is high)
module mask_range_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_W           = 7
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [4:0]  i_left0,
    input  logic [4:0]  i_left1,
    input  logic [4:0]  i_right0,
    input  logic [4:0]  i_right1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic        o_err,
    output logic [31:0] o_mask,
    output logic        o_busy,
    output logic        o_mg_trig,
    output logic        o_mg_left_or_right,
    output logic [4:0]  o_mg_bound_index,
    input  logic        i_mg_done,
    input  logic [31:0] i_mg_mask
);

    typedef enum logic [2:0] {
        StIdle,
        StLRun,
        StLRel,
        StRRun,
        StRRel,
        StResp,
        StAbort
    } state_e;

    localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic            id_q, id_d;
    logic            last_q, last_d;
    logic [4:0]      left_q, left_d;
    logic [4:0]      right_q, right_d;
    logic [31:0]     lmask_q, lmask_d;
    logic [31:0]     rmask_q, rmask_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            grant;

    logic            trig_q, trig_d;
    logic            sel_q, sel_d;
    logic [4:0]      idx_q, idx_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            err_q, err_d;
    logic [31:0]     mask_q, mask_d;
    logic            busy_q, busy_d;

    // Next-state and latched-operand logic.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        left_d  = left_q;
        right_d = right_q;
        lmask_d = lmask_q;
        rmask_d = rmask_q;
        wd_d    = wd_q;
        grant   = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_req0 || i_req1) begin
                    // On a tie the requester not served last wins; a lone requester always wins.
                    grant   = (i_req0 && i_req1) ? ~last_q : i_req1;
                    id_d    = grant;
                    left_d  = grant ? i_left1 : i_left0;
                    right_d = grant ? i_right1 : i_right0;
                    wd_d    = '0;
                    state_d = StLRun;
                end
            end
            StLRun: begin
                if (i_mg_done) begin
                    lmask_d = i_mg_mask;
                    state_d = StLRel;
                end else if (wd_q == WdLast) begin
                    state_d = StAbort;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StLRel: begin
                // Generator must return to idle before the next trig is raised.
                if (!i_mg_done) begin
                    wd_d    = '0;
                    state_d = StRRun;
                end
            end
            StRRun: begin
                if (i_mg_done) begin
                    rmask_d = i_mg_mask;
                    state_d = StRRel;
                end else if (wd_q == WdLast) begin
                    state_d = StAbort;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StRRel: begin
                if (!i_mg_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = id_q;
                state_d = StIdle;
            end
            StAbort: begin
                last_d  = id_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so that every output
    // is registered and lines up with the state it belongs to.
    always_comb begin
        trig_d = 1'b0;
        sel_d  = sel_q;
        idx_d  = idx_q;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        err_d  = 1'b0;
        mask_d = '0;
        busy_d = (state_d != StIdle);

        case (state_d)
            StLRun: begin
                trig_d = 1'b1;
                sel_d  = 1'b0;
                idx_d  = left_d;
            end
            StRRun: begin
                trig_d = 1'b1;
                sel_d  = 1'b1;
                idx_d  = right_d;
            end
            StResp: begin
                ack0_d = ~id_q;
                ack1_d = id_q;
                mask_d = lmask_q & rmask_q;
            end
            StAbort: begin
                ack0_d = ~id_q;
                ack1_d = id_q;
                err_d  = 1'b1;
            end
            default: begin
                // Release and idle states keep select and index where they were.
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            left_q  <= '0;
            right_q <= '0;
            lmask_q <= '0;
            rmask_q <= '0;
            wd_q    <= '0;
            trig_q  <= 1'b0;
            sel_q   <= 1'b0;
            idx_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            left_q  <= left_d;
            right_q <= right_d;
            lmask_q <= lmask_d;
            rmask_q <= rmask_d;
            wd_q    <= wd_d;
            trig_q  <= trig_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
        end
    end

    assign o_mg_trig          = trig_q;
    assign o_mg_left_or_right = sel_q;
    assign o_mg_bound_index   = idx_q;
    assign o_ack0             = ack0_q;
    assign o_ack1             = ack1_q;
    assign o_err              = err_q;
    assign o_mask             = mask_q;
    assign o_busy             = busy_q;

endmodule

// File: tb/tb_mask_range_sched.sv
// Bench for mask_range_sched: generator stub backed by random mask tables, an arbitration
// and mask reference model, a protocol monitor, and one task per scenario.
module tb_mask_range_sched;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0, req1;
    logic [4:0]  left0, left1, right0, right1;
    logic        ack0, ack1, err, busy, trig, sel;
    logic [31:0] mask;
    logic [4:0]  idx;
    logic        mg_done;
    logic [31:0] mg_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mask_range_sched #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .TO_W          (7)
    ) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_req0            (req0),
        .i_req1            (req1),
        .i_left0           (left0),
        .i_left1           (left1),
        .i_right0          (right0),
        .i_right1          (right1),
        .o_ack0            (ack0),
        .o_ack1            (ack1),
        .o_err             (err),
        .o_mask            (mask),
        .o_busy            (busy),
        .o_mg_trig         (trig),
        .o_mg_left_or_right(sel),
        .o_mg_bound_index  (idx),
        .i_mg_done         (mg_done),
        .i_mg_mask         (mg_mask)
    );

    // Generator stub: done rises done_dly cycles after trig, falls rel_dly cycles after trig
    // drops; the mask is looked up from per-side tables by the live index.
    logic [31:0] lm_tbl [32];
    logic [31:0] rm_tbl [32];
    int done_dly = 6;
    int rel_dly  = 1;
    bit hang     = 1'b0;
    int scnt, rcnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mg_done <= 1'b0;
            mg_mask <= '0;
            scnt    <= 0;
            rcnt    <= 0;
        end else if (trig && !mg_done) begin
            rcnt <= 0;
            if (!hang && scnt == done_dly - 1) begin
                mg_done <= 1'b1;
                mg_mask <= sel ? rm_tbl[idx] : lm_tbl[idx];
                scnt    <= 0;
            end else begin
                scnt <= scnt + 1;
            end
        end else if (!trig && mg_done) begin
            scnt <= 0;
            if (rcnt == rel_dly - 1) begin
                mg_done <= 1'b0;
                mg_mask <= '0;
                rcnt    <= 0;
            end else begin
                rcnt <= rcnt + 1;
            end
        end else begin
            scnt <= 0;
            rcnt <= 0;
        end
    end

    // Protocol monitor: counts rule breaks; scenario tasks compare the counts.
    logic       p_trig = 1'b0, p_done = 1'b0, p_sel = 1'b0;
    logic [4:0] p_idx = '0;
    int stab_viol = 0, overlap_viol = 0, mask_viol = 0, ack_viol = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if ((p_trig || p_done) && (idx !== p_idx || sel !== p_sel))
                stab_viol <= stab_viol + 1;
            if (trig && !p_trig && (mg_done || p_done))
                overlap_viol <= overlap_viol + 1;
            if (mask !== 32'h0 && !(ack0 || ack1))
                mask_viol <= mask_viol + 1;
            if ((ack0 && ack1) || (err && !(ack0 || ack1)) || (err && mask !== 32'h0))
                ack_viol <= ack_viol + 1;
        end
        p_trig <= trig;
        p_done <= mg_done;
        p_sel  <= sel;
        p_idx  <= idx;
    end

    // Reference model state.
    int model_last = 1;

    function automatic logic [31:0] exp_mask(input logic [4:0] l, input logic [4:0] r);
        return lm_tbl[l] & rm_tbl[r];
    endfunction

    // Waits for an ack and reports what was seen on the generator side along the way.
    task automatic wait_ack(input int limit, input bit churn,
                            output int id, output logic [31:0] got_mask, output logic got_err,
                            output bit to, output int trig_cycles,
                            output logic [4:0] l_first, output logic [4:0] r_first,
                            output bit l_moved, output bit r_moved);
        bit seen_l = 1'b0, seen_r = 1'b0;
        id = -1; got_mask = '0; got_err = 1'b0; to = 1'b1; trig_cycles = 0;
        l_first = '0; r_first = '0; l_moved = 1'b0; r_moved = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk);
            #1;
            if (churn && busy) begin
                left0  = 5'($urandom);
                right0 = 5'($urandom);
            end
            if (trig || mg_done) begin
                if (!sel) begin
                    if (!seen_l) begin l_first = idx; seen_l = 1'b1; end
                    else if (idx !== l_first) l_moved = 1'b1;
                end else begin
                    if (!seen_r) begin r_first = idx; seen_r = 1'b1; end
                    else if (idx !== r_first) r_moved = 1'b1;
                end
            end
            if (trig) trig_cycles++;
            if (ack0 || ack1) begin
                id = ack1 ? 1 : 0;
                got_mask = mask;
                got_err = err;
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req0 = 0; req1 = 0; left0 = 0; left1 = 0; right0 = 0; right1 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({trig, busy, ack0, ack1, err, sel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000", {trig, busy, ack0, ack1, err, sel});
        end
        checks++;
        if (mask !== 32'h0 || idx !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: got mask=%h idx=%0d required 0/0", mask, idx);
        end
        #2 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || trig !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b trig=%b required 0/0", busy, trig);
        end
        model_last = 1;
    endtask

    task automatic test_single();
        int id, tc; logic [31:0] m; logic e; bit to, lm, rm; logic [4:0] lf, rf;
        lm_tbl[3] = 32'hFFFF0000;
        rm_tbl[20] = 32'h00FFFFFF;
        done_dly = 6; rel_dly = 1;
        left0 = 5'd3; right0 = 5'd20; req0 = 1'b1;
        wait_ack(400, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req0 = 1'b0;
        checks++;
        if (to || id != 0) begin
            errors++;
            $display("FAIL single_ack: got id=%0d timeout=%0b required id=0", id, to);
        end
        checks++;
        if (m !== 32'h00FF0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL single_mask: got %h err=%b required 00ff0000 err=0", m, e);
        end
        checks++;
        if (lf !== 5'd3 || rf !== 5'd20) begin
            errors++;
            $display("FAIL single_index: got L=%0d R=%0d required 3/20", lf, rf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack0 !== 1'b0 || mask !== 32'h0) begin
            errors++;
            $display("FAIL single_pulse: got ack0=%b mask=%h required 0/0", ack0, mask);
        end
        model_last = 0;
    endtask

    task automatic test_contention();
        int id, tc, want; logic [31:0] m, wm; logic e; bit to, lm, rm; logic [4:0] lf, rf;
        logic [4:0] l[2], r[2];
        for (int i = 0; i < 2; i++) begin
            l[i] = 5'($urandom); r[i] = 5'($urandom);
        end
        left0 = l[0]; right0 = r[0]; left1 = l[1]; right1 = r[1];
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 8; t++) begin
            want = 1 - model_last;
            wm = exp_mask(l[want], r[want]);
            wait_ack(600, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
            checks++;
            if (to || id != want || m !== wm || e !== 1'b0) begin
                errors++;
                $display("FAIL contention_%0d: got id=%0d mask=%h err=%b to=%0b required id=%0d mask=%h",
                         t, id, m, e, to, want, wm);
            end
            model_last = want;
            // Served requester re-issues with fresh bounds; stub timing varies too.
            l[want] = 5'($urandom); r[want] = 5'($urandom);
            if (want == 0) begin left0 = l[0]; right0 = r[0]; end
            else begin left1 = l[1]; right1 = r[1]; end
            done_dly = $urandom_range(1, 8);
            rel_dly = $urandom_range(1, 3);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        checks++;
        if (mask_viol != 0 || ack_viol != 0) begin
            errors++;
            $display("FAIL contention_outputs: got mask_viol=%0d ack_viol=%0d required 0/0",
                     mask_viol, ack_viol);
        end
    endtask

    task automatic test_churn();
        int id, tc; logic [31:0] m, wm; logic e; bit to, lm, rm; logic [4:0] lf, rf, l, r;
        l = 5'($urandom); r = 5'($urandom);
        wm = exp_mask(l, r);
        done_dly = 5; rel_dly = 2;
        left0 = l; right0 = r; req0 = 1'b1;
        wait_ack(400, 1'b1, id, m, e, to, tc, lf, rf, lm, rm);
        req0 = 1'b0;
        model_last = 0;
        checks++;
        if (lf !== l || rf !== r || lm || rm) begin
            errors++;
            $display("FAIL churn_index: got L=%0d R=%0d moved=%0b%0b required L=%0d R=%0d moved=00",
                     lf, rf, lm, rm, l, r);
        end
        checks++;
        if (to || id != 0 || m !== wm) begin
            errors++;
            $display("FAIL churn_mask: got id=%0d mask=%h required id=0 mask=%h", id, m, wm);
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL churn_stability: got %0d index changes under trig/done required 0",
                     stab_viol);
        end
    endtask

    task automatic test_hung();
        int id, tc; logic [31:0] m, wm; logic e; bit to, lm, rm; logic [4:0] lf, rf, l, r;
        hang = 1'b1;
        left0 = 5'($urandom); right0 = 5'($urandom); req0 = 1'b1;
        wait_ack(500, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req0 = 1'b0;
        model_last = 0;
        checks++;
        if (to || id != 0 || e !== 1'b1 || m !== 32'h0) begin
            errors++;
            $display("FAIL hung_abort: got id=%0d err=%b mask=%h to=%0b required id=0 err=1 mask=0",
                     id, e, m, to);
        end
        checks++;
        if (tc != TIMEOUT) begin
            errors++;
            $display("FAIL hung_trig_len: got %0d trig cycles required %0d", tc, TIMEOUT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL hung_idle: got busy=%b ack0=%b err=%b required 0/0/0", busy, ack0, err);
        end
        hang = 1'b0;
        done_dly = 4; rel_dly = 1;
        l = 5'($urandom); r = 5'($urandom);
        wm = exp_mask(l, r);
        left1 = l; right1 = r; req1 = 1'b1;
        wait_ack(400, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req1 = 1'b0;
        model_last = 1;
        checks++;
        if (to || id != 1 || m !== wm || e !== 1'b0) begin
            errors++;
            $display("FAIL hung_recover: got id=%0d mask=%h err=%b required id=1 mask=%h err=0",
                     id, m, e, wm);
        end
    endtask

    task automatic test_slow_release();
        int id, tc; logic [31:0] m, wm; logic e; bit to, lm, rm; logic [4:0] lf, rf, l, r;
        done_dly = 3; rel_dly = 10;
        l = 5'($urandom); r = 5'($urandom);
        wm = exp_mask(l, r);
        left0 = l; right0 = r; req0 = 1'b1;
        wait_ack(400, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req0 = 1'b0;
        model_last = 0;
        checks++;
        if (to || id != 0 || m !== wm || e !== 1'b0) begin
            errors++;
            $display("FAIL slow_release_mask: got id=%0d mask=%h err=%b required id=0 mask=%h",
                     id, m, e, wm);
        end
        checks++;
        if (tc != 2 * done_dly + 2 || overlap_viol != 0) begin
            errors++;
            $display("FAIL slow_release_overlap: got trig=%0d overlaps=%0d required trig=%0d overlaps=0",
                     tc, overlap_viol, 2 * done_dly + 2);
        end
    endtask

    task automatic test_reset_mid();
        int id, tc; logic [31:0] m, wm; logic e; bit to, lm, rm, hit; logic [4:0] lf, rf, l, r;
        done_dly = 20; rel_dly = 1;
        left0 = 5'($urandom); right0 = 5'($urandom); req0 = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (trig && sel) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: got no right-side run required one");
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({trig, busy, ack0, ack1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got trig/busy/ack0/ack1=%b required 0000",
                     {trig, busy, ack0, ack1});
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        model_last = 1;
        done_dly = 2;
        for (int i = 0; i < 2; i++) begin
            l = 5'($urandom); r = 5'($urandom);
            if (i == 0) begin left0 = l; right0 = r; end
            else begin left1 = l; right1 = r; end
        end
        req0 = 1'b1; req1 = 1'b1;
        wm = exp_mask(left0, right0);
        wait_ack(400, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req0 = 1'b0;
        checks++;
        if (to || id != 1 - model_last || m !== wm) begin
            errors++;
            $display("FAIL reset_mid_tie: got id=%0d mask=%h required id=0 mask=%h", id, m, wm);
        end
        model_last = 0;
        wm = exp_mask(left1, right1);
        wait_ack(400, 1'b0, id, m, e, to, tc, lf, rf, lm, rm);
        req1 = 1'b0;
        model_last = 1;
        checks++;
        if (to || id != 1 || m !== wm) begin
            errors++;
            $display("FAIL reset_mid_next: got id=%0d mask=%h required id=1 mask=%h", id, m, wm);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            lm_tbl[i] = $urandom;
            rm_tbl[i] = $urandom;
        end
        test_reset();
        test_single();
        test_contention();
        test_churn();
        test_hung();
        test_slow_release();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mask_range_sched.md
Name: mask_range_sched

Overview:
- Scheduler and arbiter in front of the shared 32-bit mask generator in the connected-domain filter.
- Accepts range requests (left bound, right bound) from two requesters and arbitrates round-robin.
- For each granted request, runs the generator twice: left mask first, then right mask. Returns the AND of the two masks with a one-cycle ack.
- Owns the generator's level trig/done handshake and holds the bound index stable for the whole generator run.
- Includes a watchdog against a hung generator.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent waiting for i_mg_done to rise in one generator run before aborting.
- TO_W, 7, width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  active-low asynchronous reset.
- i_req0 / i_req1  in  1  request level; held high until the matching ack.
- i_left0 / i_left1  in  5  left bound index; stable while the request is high.
- i_right0 / i_right1  in  5  right bound index; stable while the request is high.
- o_ack0 / o_ack1  out  1  one-cycle completion pulse to the requester.
- o_err  out  1  pulses with an ack when that request timed out.
- o_mask  out  32  range mask; valid only in the ack cycle, 0 otherwise.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_mg_trig  out  1  generator trig (level).
- o_mg_left_or_right  out  1  generator select: 0 = left, 1 = right.
- o_mg_bound_index  out  5  generator bound index.
- i_mg_done  in  1  generator done level.
- i_mg_mask  in  32  generator mask; valid while i_mg_done is high.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Round-robin pointer set to "last = 1", so req0 wins the first tie. Latched bounds, latched masks and watchdog counter are 0.
- The interface is clocked with one clock domain. Reset is asynchronous and active-low.
- All outputs are registered.

FSM states and transitions:
- IDLE: if any request is high, grant by round-robin. Latch the winner's ID, left bound and right bound. Go to L_RUN. With only one requester high, it is granted regardless of the pointer.
- L_RUN:
  - Drive o_mg_trig = 1, o_mg_left_or_right = 0, o_mg_bound_index = latched left bound.
  - On i_mg_done = 1: latch i_mg_mask as lmask, go to L_REL.
- L_REL:
  - Drive trig = 0; bound index and select are held.
  - Wait for i_mg_done = 0 (the generator returns to IDLE), then go to R_RUN.
- R_RUN: same as L_RUN with select = 1 and the latched right bound. On done, latch rmask and go to R_REL.
- R_REL: trig = 0; on i_mg_done = 0, go to RESP.
- RESP:
  - For exactly 1 cycle: o_ack[id] = 1, o_mask = lmask & rmask.
  - Update the pointer to the served ID.
  - Go to IDLE.
  - Requests are not re-sampled in this cycle. The earliest next grant is in the IDLE cycle that follows.

Watchdog:
- Counter clears on entry to L_RUN and R_RUN and increments each cycle in those states.
- When it reaches TIMEOUT_CYCLES with i_mg_done still 0: drop trig and go to ABORT.
- ABORT: 1 cycle, o_ack[id] = 1, o_err = 1, o_mask = 0, pointer updated, then IDLE.
- The REL states have no timeout.

Stability and simultaneous events:
- o_mg_bound_index and o_mg_left_or_right never change while trig is high or while i_mg_done is high. The generator samples the index live, so this is mandatory.
- The latched bounds ignore any changes on the i_left/i_right inputs after the grant.
- Both requests high in IDLE: the non-last-served requester wins. No request is ever starved; alternation is strict under sustained contention.
- A requester that drops its request before ack is still completed and acked; the ack is harmless.
- Reset mid-operation forces IDLE with trig = 0 and ack = 0 immediately (asynchronous).

Test Plan:
- Single request, generator stub answering left = 0xFFFF0000, right = 0x00FFFFFF. Stub raises done 6 cycles after trig and drops it 1 cycle after trig falls. i_req0 with L = 3, R = 20 -> o_mg_bound_index = 3 with select 0, then 20 with select 1; o_ack0 pulses once with o_mask = 0x00FF0000, o_err = 0.
- Contention: req0 and req1 both held high for 4 transactions -> acks arrive in order 0, 1, 0, 1. o_mask is nonzero only in ack cycles.
- Bound churn: change i_left0 every cycle after the grant -> o_mg_bound_index stays at the latched value throughout L_RUN and L_REL. Checker asserts index stability whenever trig or done is high.
- Hung generator: stub never raises done, TIMEOUT_CYCLES = 64 -> trig drops after 64 cycles in L_RUN; o_ack0 and o_err pulse together, o_mask = 0, then FSM returns to IDLE. A subsequent normal request completes correctly.
- Slow release: stub holds done 10 cycles after trig falls -> R_RUN does not start until done is low. No trig overlaps done.
- Async reset asserted during R_RUN -> o_mg_trig, o_busy and the acks go to 0 within the reset edge. After release, the first request is granted to req0 on a tie.
